prog_timer_multi: RTL and testbench

- Parametrised, multi-channel successor to the single programmable timer.
- One shared 6-bit prescaler, advanced from clk/2, feeds CHANNELS independent WIDTH-bit downcounters.
- Each channel has its own clock tap, reload value, auto-reload or one-shot mode, and interrupt factor flag.
- Sits on the CPU I/O register bus; factor flags go to the interrupt controller.

---
 rtl/prog_timer_multi_pkg.sv | 33 +++
 rtl/prog_timer_multi_channel.sv | 62 ++++++
 rtl/prog_timer_multi.sv | 93 +++++++++
 tb/tb_prog_timer_multi.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_timer_multi_pkg.sv
// Shared types and helpers for the multi-channel programmable timer.
package prog_timer_pkg;

    localparam int unsigned PRESCALE_BITS = 6;

    typedef enum logic [2:0] {
        SEL_EXT0,
        SEL_EXT1,
        SEL_256,
        SEL_512,
        SEL_1K,
        SEL_2K,
        SEL_4K,
        SEL_8K
    } clk_sel_t;

    // Prescaler bit feeding a given clock select; external codes return 0 (unused).
    function automatic logic [2:0] tap_index(input clk_sel_t sel);
        logic [2:0] idx;
        idx = 3'd0;
        case (sel)
            SEL_256: idx = 3'd5;
            SEL_512: idx = 3'd4;
            SEL_1K:  idx = 3'd3;
            SEL_2K:  idx = 3'd2;
            SEL_4K:  idx = 3'd1;
            SEL_8K:  idx = 3'd0;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/prog_timer_multi_channel.sv
// One timer channel: falling-edge tick detection, downcounter, one-shot/auto-reload and sticky flag.
module prog_timer_channel #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src,
    input  logic             chain,
    input  logic             enable,
    input  logic             restart,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] reload,
    input  logic             factor_clear,
    output logic             factor_flag,
    output logic             underflow,
    output logic             running,
    output logic [WIDTH-1:0] count
);

    logic             prev;
    logic             tick;
    logic [WIDTH-1:0] reload_eff;

    assign reload_eff = (reload != '0) ? reload : '1;
    // A chained source is already a one-cycle pulse, so it bypasses edge detection.
    assign tick = chain ? src : (prev & ~src);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= 1'b0;
            factor_flag <= 1'b0;
            underflow   <= 1'b0;
            running     <= 1'b1;
            count       <= '1;
        end else begin
            prev      <= src;
            underflow <= 1'b0;
            if (factor_clear) begin
                factor_flag <= 1'b0;
            end
            if (restart) begin
                count   <= reload_eff;
                running <= 1'b1;
            end else if (tick && enable && running) begin
                if (count == WIDTH'(1)) begin
                    underflow   <= 1'b1;
                    factor_flag <= 1'b1;
                    if (one_shot) begin
                        count   <= '0;
                        running <= 1'b0;
                    end else begin
                        count <= reload_eff;
                    end
                end else begin
                    // count == 0 wraps to all-ones here without counting as an expiry
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prog_timer_multi.sv
// Multi-channel programmable timer: shared prescaler, per-channel source muxing and channel array.
// Optional macro PROG_TIMER_CHAIN_EN lets clock_sel 001 on channel i>0 count channel i-1 underflows.
module prog_timer_multi #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       input_k,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       restart,
    input  logic [CHANNELS-1:0]       one_shot,
    input  logic [3*CHANNELS-1:0]     clock_sel,
    input  logic [WIDTH*CHANNELS-1:0] counter_reload,
    input  logic [CHANNELS-1:0]       factor_clear,
    output logic [CHANNELS-1:0]       factor_flags,
    output logic [CHANNELS-1:0]       underflow,
    output logic [CHANNELS-1:0]       running,
    output logic [WIDTH*CHANNELS-1:0] downcounter
);

    import prog_timer_pkg::*;

    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     divider;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            divider   <= 1'b0;
        end else begin
            divider <= ~divider;
            if (divider && (|enable)) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_sel_t sel;
        logic     src;
        logic     chain;

        assign sel = clk_sel_t'(clock_sel[3*i +: 3]);

`ifdef PROG_TIMER_CHAIN_EN
        logic prev_uf;
        if (i > 0) begin : g_prev
            assign prev_uf = underflow[i-1];
        end else begin : g_first
            assign prev_uf = 1'b0;
        end

        always_comb begin
            chain = 1'b0;
            src   = input_k[i];
            if (sel == SEL_EXT1 && i > 0) begin
                chain = 1'b1;
                src   = prev_uf;
            end else if (sel != SEL_EXT0 && sel != SEL_EXT1) begin
                src = prescaler[tap_index(sel)];
            end
        end
`else
        always_comb begin
            chain = 1'b0;
            src   = input_k[i];
            if (sel != SEL_EXT0 && sel != SEL_EXT1) begin
                src = prescaler[tap_index(sel)];
            end
        end
`endif

        prog_timer_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .src         (src),
            .chain       (chain),
            .enable      (enable[i]),
            .restart     (restart[i]),
            .one_shot    (one_shot[i]),
            .reload      (counter_reload[WIDTH*i +: WIDTH]),
            .factor_clear(factor_clear[i]),
            .factor_flag (factor_flags[i]),
            .underflow   (underflow[i]),
            .running     (running[i]),
            .count       (downcounter[WIDTH*i +: WIDTH])
        );
    end

endmodule

// File: tb/tb_prog_timer_multi.sv
// Directed self-checking bench for prog_timer_multi (CHANNELS=2, WIDTH=8).
module tb_prog_timer_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  input_k, enable, restart, one_shot, factor_clear;
    logic [5:0]  clock_sel;
    logic [15:0] counter_reload;
    logic [1:0]  factor_flags, underflow, running;
    logic [15:0] downcounter;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    prog_timer_multi #(
        .CHANNELS(2),
        .WIDTH   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_k       (input_k),
        .enable        (enable),
        .restart       (restart),
        .one_shot      (one_shot),
        .clock_sel     (clock_sel),
        .counter_reload(counter_reload),
        .factor_clear  (factor_clear),
        .factor_flags  (factor_flags),
        .underflow     (underflow),
        .running       (running),
        .downcounter   (downcounter)
    );

    typedef struct packed {
        logic [1:0] ik;
        logic [1:0] en;
        logic [1:0] rst;
        logic [1:0] clr;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] flags;
        logic [1:0] uf;
        logic [1:0] run;
    } vec_t;

    vec_t vt [25];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        restart      = 2'b00;
        factor_clear = 2'b00;
        input_k      = 2'b00;
        step();
        step();
    endtask

    initial begin
        int unsigned n_uf0;
        int unsigned n_uf1;
        logic [7:0]  exp_c0;

        // ik, en, rst, clr, c0, c1, flags, uf, run
        vt[0]  = '{2'b00, 2'b11, 2'b11, 2'b00, 8'd3, 8'd2, 2'b00, 2'b00, 2'b11};
        vt[1]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'd3, 8'd2, 2'b00, 2'b00, 2'b11};
        vt[2]  = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd2, 8'd1, 2'b00, 2'b00, 2'b11};
        vt[3]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'd2, 8'd1, 2'b00, 2'b00, 2'b11};
        vt[4]  = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd1, 8'd0, 2'b10, 2'b10, 2'b01};
        vt[5]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'd1, 8'd0, 2'b10, 2'b00, 2'b01};
        vt[6]  = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd3, 8'd0, 2'b11, 2'b01, 2'b01};
        vt[7]  = '{2'b11, 2'b11, 2'b00, 2'b10, 8'd3, 8'd0, 2'b01, 2'b00, 2'b01};
        vt[8]  = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd2, 8'd0, 2'b01, 2'b00, 2'b01};
        vt[9]  = '{2'b11, 2'b11, 2'b10, 2'b00, 8'd2, 8'd2, 2'b01, 2'b00, 2'b11};
        vt[10] = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd1, 8'd1, 2'b01, 2'b00, 2'b11};
        vt[11] = '{2'b11, 2'b11, 2'b00, 2'b00, 8'd1, 8'd1, 2'b01, 2'b00, 2'b11};
        vt[12] = '{2'b00, 2'b11, 2'b00, 2'b01, 8'd3, 8'd0, 2'b11, 2'b11, 2'b01};
        vt[13] = '{2'b11, 2'b11, 2'b01, 2'b00, 8'd3, 8'd0, 2'b11, 2'b00, 2'b01};
        vt[14] = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd2, 8'd0, 2'b11, 2'b00, 2'b01};
        vt[15] = '{2'b11, 2'b11, 2'b00, 2'b00, 8'd2, 8'd0, 2'b11, 2'b00, 2'b01};
        vt[16] = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd1, 8'd0, 2'b11, 2'b00, 2'b01};
        vt[17] = '{2'b11, 2'b11, 2'b00, 2'b01, 8'd1, 8'd0, 2'b10, 2'b00, 2'b01};
        vt[18] = '{2'b00, 2'b11, 2'b01, 2'b00, 8'd3, 8'd0, 2'b10, 2'b00, 2'b01};
        vt[19] = '{2'b11, 2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 2'b10, 2'b00, 2'b01};
        vt[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 2'b10, 2'b00, 2'b01};
        vt[21] = '{2'b11, 2'b00, 2'b10, 2'b00, 8'd3, 8'd2, 2'b10, 2'b00, 2'b11};
        vt[22] = '{2'b00, 2'b00, 2'b00, 2'b00, 8'd3, 8'd2, 2'b10, 2'b00, 2'b11};
        vt[23] = '{2'b11, 2'b11, 2'b00, 2'b00, 8'd3, 8'd2, 2'b10, 2'b00, 2'b11};
        vt[24] = '{2'b00, 2'b11, 2'b00, 2'b00, 8'd2, 8'd1, 2'b10, 2'b00, 2'b11};

        // Table: both channels clocked from input_k; ch0 auto-reload 3, ch1 one-shot 2
        enable         = 2'b11;
        one_shot       = 2'b10;
        clock_sel      = 6'b000_000;
        counter_reload = {8'd2, 8'd3};
        do_reset();
        chk("reset_count", 32'(downcounter), 32'h0000_FFFF);
        chk("reset_flags", 32'(factor_flags), 32'd0);
        chk("reset_uf", 32'(underflow), 32'd0);
        chk("reset_run", 32'(running), 32'd3);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            input_k      = vt[i].ik;
            enable       = vt[i].en;
            restart      = vt[i].rst;
            factor_clear = vt[i].clr;
            step();
            chk($sformatf("vec%0d_count", i), 32'(downcounter), 32'({vt[i].c1, vt[i].c0}));
            chk($sformatf("vec%0d_flags", i), 32'(factor_flags), 32'(vt[i].flags));
            chk($sformatf("vec%0d_uf", i), 32'(underflow), 32'(vt[i].uf));
            chk($sformatf("vec%0d_run", i), 32'(running), 32'(vt[i].run));
        end
        restart      = 2'b00;
        factor_clear = 2'b00;

        // Reset in the middle of activity
        reset = 1'b1;
        step();
        chk("midreset_count", 32'(downcounter), 32'h0000_FFFF);
        chk("midreset_flags", 32'(factor_flags), 32'd0);
        chk("midreset_run", 32'(running), 32'd3);

        // Prescaler: ch0 on fastest tap, only enable[0]; first tick lands 4 clk after release
        enable         = 2'b01;
        one_shot       = 2'b00;
        clock_sel      = 6'b000_111;
        counter_reload = {8'd2, 8'd3};
        do_reset();
        reset   = 1'b0;
        restart = 2'b01;
        step();
        chk("pre_e0_c0", 32'(downcounter[7:0]), 32'd3);
        restart = 2'b00;
        for (int e = 1; e <= 25; e++) begin
            step();
            if (e < 4)       exp_c0 = 8'd3;
            else if (e < 8)  exp_c0 = 8'd2;
            else if (e < 12) exp_c0 = 8'd1;
            else if (e < 16) exp_c0 = 8'd3;
            else if (e < 20) exp_c0 = 8'd2;
            else if (e < 24) exp_c0 = 8'd1;
            else             exp_c0 = 8'd3;
            chk($sformatf("pre_e%0d_c0", e), 32'(downcounter[7:0]), 32'(exp_c0));
            chk($sformatf("pre_e%0d_uf", e), 32'(underflow), (e == 12 || e == 24) ? 32'd1 : 32'd0);
            chk($sformatf("pre_e%0d_c1", e), 32'(downcounter[15:8]), 32'hFF);
            if (e == 11) chk("pre_flag_before", 32'(factor_flags), 32'd0);
            if (e == 12) chk("pre_flag_set", 32'(factor_flags), 32'd1);
        end

        // Reload value 0 behaves as 255
        enable         = 2'b01;
        one_shot       = 2'b00;
        clock_sel      = 6'b000_000;
        counter_reload = {8'd2, 8'd0};
        do_reset();
        reset   = 1'b0;
        restart = 2'b01;
        step();
        restart = 2'b00;
        chk("r0_restart", 32'(downcounter[7:0]), 32'hFF);
        n_uf0 = 0;
        for (int t = 0; t < 254; t++) begin
            input_k = 2'b01;
            step();
            input_k = 2'b00;
            step();
            if (underflow[0]) n_uf0++;
        end
        chk("r0_no_early_uf", 32'(n_uf0), 32'd0);
        chk("r0_count1", 32'(downcounter[7:0]), 32'd1);
        input_k = 2'b01;
        step();
        input_k = 2'b00;
        step();
        chk("r0_expiry_uf", 32'(underflow), 32'd1);
        chk("r0_expiry_count", 32'(downcounter[7:0]), 32'hFF);
        chk("r0_expiry_flag", 32'(factor_flags), 32'd1);

        // Clock select 001 on ch1: chained to ch0 underflow or plain input_k[1]
        enable         = 2'b11;
        one_shot       = 2'b00;
        clock_sel      = 6'b001_000;
        counter_reload = {8'd3, 8'd2};
        do_reset();
        reset   = 1'b0;
        restart = 2'b11;
        step();
        restart = 2'b00;
        chk("sel1_restart", 32'(downcounter), 32'h0000_0302);
        n_uf0 = 0;
        n_uf1 = 0;
        for (int s = 0; s < 26; s++) begin
            input_k = (s < 24 && s % 2 == 1) ? 2'b00 : 2'b11;
            step();
            if (underflow[0]) n_uf0++;
            if (underflow[1]) n_uf1++;
        end
        chk("sel1_uf0_count", 32'(n_uf0), 32'd6);
`ifdef PROG_TIMER_CHAIN_EN
        chk("sel1_uf1_count", 32'(n_uf1), 32'd2);
`else
        chk("sel1_uf1_count", 32'(n_uf1), 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
